// File: rtl/mem_data_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_data_ctrl_if
// Brief    : Request/response and byte-RAM bus bundle for mem_data_ctrl.
//            ioFull_i exists only when MEMCTRL_IO_STALL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_data_ctrl_if;
  logic        dataEn_i;
  logic        dataRw_i;
  logic [2:0]  dataWid_i;
  logic [31:0] dataAddr_i;
  logic [31:0] dataData_i;
  logic        Rdy_o;
  logic [31:0] dataData_o;
  logic        Busy_o;
  logic [31:0] ramA_o;
  logic [7:0]  ramDout_o;
  logic        ramWr_o;
  logic [7:0]  ramDin_i;

`ifdef MEMCTRL_IO_STALL_EN
  logic        ioFull_i;

  modport master (
    output dataEn_i, dataRw_i, dataWid_i, dataAddr_i, dataData_i, ramDin_i, ioFull_i,
    input  Rdy_o, dataData_o, Busy_o, ramA_o, ramDout_o, ramWr_o
  );

  modport slave (
    input  dataEn_i, dataRw_i, dataWid_i, dataAddr_i, dataData_i, ramDin_i, ioFull_i,
    output Rdy_o, dataData_o, Busy_o, ramA_o, ramDout_o, ramWr_o
  );
`else
  modport master (
    output dataEn_i, dataRw_i, dataWid_i, dataAddr_i, dataData_i, ramDin_i,
    input  Rdy_o, dataData_o, Busy_o, ramA_o, ramDout_o, ramWr_o
  );

  modport slave (
    input  dataEn_i, dataRw_i, dataWid_i, dataAddr_i, dataData_i, ramDin_i,
    output Rdy_o, dataData_o, Busy_o, ramA_o, ramDout_o, ramWr_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mem_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_data_ctrl
// Brief    : Serialises 1/2/4-byte load/store requests onto a byte-wide RAM.
//            Optional macro MEMCTRL_IO_STALL_EN adds the WAIT_IO stall state.
// Revision : 1.0 - initial release
// ============================================================================
module mem_data_ctrl (
  input  wire            clk,
  input  wire            rst,
  input  wire            rdy,
  mem_data_ctrl_if.slave bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_READ    = 2'd1;
  localparam logic [1:0] c_WRITE   = 2'd2;
`ifdef MEMCTRL_IO_STALL_EN
  localparam logic [1:0] c_WAIT_IO = 2'd3;
`endif

  logic [1:0]  r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_n, w_n_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_acc, w_acc_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic [31:0] r_ram_a, w_ram_a_nxt;
  logic [7:0]  r_ram_dout, w_ram_dout_nxt;
  logic        r_ram_wr, w_ram_wr_nxt;
  logic        r_rdy_o, w_rdy_nxt;

  logic [2:0]  w_wid;
  logic [2:0]  w_cnt_inc;
  logic [31:0] w_addr_inc;
  logic [4:0]  w_lane_cur;
  logic [4:0]  w_lane_nxt;
  logic        w_last;
  logic        w_io_hold;

  // Unsupported widths fall back to a full word.
  always_comb begin
    case (bus.dataWid_i)
      3'd1, 3'd2, 3'd4: w_wid = bus.dataWid_i;
      default:          w_wid = 3'd4;
    endcase
  end

  assign w_cnt_inc  = r_cnt + 3'd1;
  assign w_addr_inc = r_addr + {29'd0, w_cnt_inc};
  assign w_lane_cur = {r_cnt[1:0], 3'b000};
  assign w_lane_nxt = {w_cnt_inc[1:0], 3'b000};
  assign w_last     = (w_cnt_inc == r_n);

`ifdef MEMCTRL_IO_STALL_EN
  assign w_io_hold = bus.dataRw_i && (bus.dataAddr_i[17:16] == 2'b11) && bus.ioFull_i;
`else
  assign w_io_hold = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= 3'd0;
    end else if (rdy) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_IDLE: begin
        if (bus.dataEn_i) begin
          w_cnt_nxt = 3'd0;
          if (!bus.dataRw_i)
            w_state_nxt = c_READ;
`ifdef MEMCTRL_IO_STALL_EN
          else if (w_io_hold)
            w_state_nxt = c_WAIT_IO;
`endif
          else
            w_state_nxt = c_WRITE;
        end
      end
      c_READ, c_WRITE: begin
        if (w_last) begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
`ifdef MEMCTRL_IO_STALL_EN
      c_WAIT_IO: begin
        if (!bus.ioFull_i) begin
          w_state_nxt = c_WRITE;
          w_cnt_nxt   = 3'd0;
        end
      end
`endif
      default: begin
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Output / datapath next values; RAM bus values are registered one cycle ahead.
  always_comb begin
    w_ram_a_nxt    = r_ram_a;
    w_ram_wr_nxt   = r_ram_wr;
    w_ram_dout_nxt = r_ram_dout;
    w_rdy_nxt      = 1'b0;
    w_rdata_nxt    = r_rdata;
    w_acc_nxt      = r_acc;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_n_nxt        = r_n;
    case (r_state)
      c_IDLE: begin
        w_ram_a_nxt  = 32'd0;
        w_ram_wr_nxt = 1'b0;
        if (bus.dataEn_i) begin
          w_addr_nxt  = bus.dataAddr_i;
          w_wdata_nxt = bus.dataData_i;
          w_n_nxt     = w_wid;
          w_acc_nxt   = 32'd0;
          if (!bus.dataRw_i) begin
            w_ram_a_nxt = bus.dataAddr_i;
          end else if (!w_io_hold) begin
            w_ram_a_nxt    = bus.dataAddr_i;
            w_ram_wr_nxt   = 1'b1;
            w_ram_dout_nxt = bus.dataData_i[7:0];
          end
        end
      end
      c_READ: begin
        w_acc_nxt[w_lane_cur +: 8] = bus.ramDin_i;
        if (w_last) begin
          w_ram_a_nxt = 32'd0;
          w_rdy_nxt   = 1'b1;
          w_rdata_nxt = w_acc_nxt;
        end else begin
          w_ram_a_nxt = w_addr_inc;
        end
        w_ram_wr_nxt = 1'b0;
      end
      c_WRITE: begin
        if (w_last) begin
          w_ram_a_nxt    = 32'd0;
          w_ram_wr_nxt   = 1'b0;
          w_ram_dout_nxt = 8'd0;
          w_rdy_nxt      = 1'b1;
        end else begin
          w_ram_a_nxt    = w_addr_inc;
          w_ram_wr_nxt   = 1'b1;
          w_ram_dout_nxt = r_wdata[w_lane_nxt +: 8];
        end
      end
`ifdef MEMCTRL_IO_STALL_EN
      c_WAIT_IO: begin
        if (!bus.ioFull_i) begin
          w_ram_a_nxt    = r_addr;
          w_ram_wr_nxt   = 1'b1;
          w_ram_dout_nxt = r_wdata[7:0];
        end
      end
`endif
      default: begin
        w_ram_a_nxt  = 32'd0;
        w_ram_wr_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; rdy low freezes everything, including a pending Rdy_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_a    <= 32'd0;
      r_ram_wr   <= 1'b0;
      r_ram_dout <= 8'd0;
      r_rdy_o    <= 1'b0;
      r_rdata    <= 32'd0;
      r_acc      <= 32'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_n        <= 3'd4;
    end else if (rdy) begin
      r_ram_a    <= w_ram_a_nxt;
      r_ram_wr   <= w_ram_wr_nxt;
      r_ram_dout <= w_ram_dout_nxt;
      r_rdy_o    <= w_rdy_nxt;
      r_rdata    <= w_rdata_nxt;
      r_acc      <= w_acc_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_n        <= w_n_nxt;
    end
  end

  assign bus.ramA_o     = r_ram_a;
  assign bus.ramWr_o    = r_ram_wr;
  assign bus.ramDout_o  = r_ram_dout;
  assign bus.Rdy_o      = r_rdy_o;
  assign bus.dataData_o = r_rdata;
  assign bus.Busy_o     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_data_ctrl
// Brief    : Scoreboard bench for mem_data_ctrl with a byte-RAM model.
//            The WAIT_IO scenario runs only when MEMCTRL_IO_STALL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_data_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  mem_data_ctrl_if bus ();

  mem_data_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] sb_q[$];
  logic [31:0] last_rd = 32'd0;
  logic        prev_rdy_o = 1'b0;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem [0:1023];

  // Combinational-read RAM model indexed by the low 10 address bits
  assign bus.ramDin_i = mem[bus.ramA_o[9:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RAM write port, preload and response scoreboard
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[10'h102] = 8'h80;
      mem[10'h3FF] = 8'hAB;
      mem[10'h000] = 8'hCD;
      mem_ready    = 1'b1;
    end else if (bus.ramWr_o) begin
      mem[bus.ramA_o[9:0]] = bus.ramDout_o;
    end
    if (bus.Rdy_o && !prev_rdy_o) begin
      if (sb_q.size() == 0) check("spurious_rdy", 32'd1, 32'd0);
      else                  check("rdata", bus.dataData_o, sb_q.pop_front());
    end
    prev_rdy_o = bus.Rdy_o;
  end

  // Issues one request at the next edge and checks the RAM bus cycle by cycle
  task automatic do_req(input logic rw, input logic [2:0] wid, input logic [31:0] addr,
                        input logic [31:0] data, input int n, input int stall_k,
                        input int stall_len, input logic [31:0] exp_rd);
    logic [31:0] a;
    bus.dataEn_i   = 1'b1;
    bus.dataRw_i   = rw;
    bus.dataWid_i  = wid;
    bus.dataAddr_i = addr;
    bus.dataData_i = data;
    sb_q.push_back(rw ? last_rd : exp_rd);
    if (!rw) last_rd = exp_rd;
    @(posedge clk); #1;
    bus.dataEn_i   = 1'b0;
    bus.dataAddr_i = ~addr;
    bus.dataData_i = ~data;
    check("busy_start", {31'd0, bus.Busy_o}, 32'd1);
    check("rdy_low", {31'd0, bus.Rdy_o}, 32'd0);
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      check("ram_a", bus.ramA_o, a);
      check("ram_wr", {31'd0, bus.ramWr_o}, {31'd0, rw});
      if (rw) check("ram_dout", {24'd0, bus.ramDout_o}, (data >> (8 * k)) & 32'hFF);
      if (k == stall_k) begin
        rdy = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          check("stall_a", bus.ramA_o, a);
          check("stall_rdy", {31'd0, bus.Rdy_o}, 32'd0);
        end
        rdy = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("rdy_pulse", {31'd0, bus.Rdy_o}, 32'd1);
    check("busy_end", {31'd0, bus.Busy_o}, 32'd0);
    check("ram_wr_end", {31'd0, bus.ramWr_o}, 32'd0);
    check("ram_a_end", bus.ramA_o, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    rdy            = 1'b1;
    bus.dataEn_i   = 1'b1;
    bus.dataRw_i   = 1'b1;
    bus.dataWid_i  = 3'd4;
    bus.dataAddr_i = 32'h0000_0300;
    bus.dataData_i = 32'hFFFF_FFFF;
`ifdef MEMCTRL_IO_STALL_EN
    bus.ioFull_i   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.dataEn_i = 1'b0;
    check("rst_busy", {31'd0, bus.Busy_o}, 32'd0);
    check("rst_rdy", {31'd0, bus.Rdy_o}, 32'd0);
    check("rst_wr", {31'd0, bus.ramWr_o}, 32'd0);
    check("rst_a", bus.ramA_o, 32'd0);
    check("rst_dout", {24'd0, bus.ramDout_o}, 32'd0);
    check("rst_data", bus.dataData_o, 32'd0);
    @(posedge clk); #1;

    do_req(1'b0, 3'd1, 32'h0000_0102, 32'd0, 1, -1, 0, 32'h0000_0080);
    do_req(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd0, 2, -1, 0, 32'h0000_CDAB);
    do_req(1'b1, 3'd4, 32'h0000_0100, 32'h1122_3344, 4, -1, 0, 32'd0);
    do_req(1'b0, 3'd4, 32'h0000_0100, 32'd0, 4, -1, 0, 32'h1122_3344);
    do_req(1'b1, 3'd2, 32'h0000_0200, 32'hAAAA_5566, 2, -1, 0, 32'd0);
    do_req(1'b0, 3'd3, 32'h0000_0200, 32'd0, 4, -1, 0, 32'h5958_5566);
    do_req(1'b0, 3'd4, 32'h0000_0100, 32'd0, 4, 1, 3, 32'h1122_3344);

    // Reset in the middle of a word store
    bus.dataEn_i   = 1'b1;
    bus.dataRw_i   = 1'b1;
    bus.dataWid_i  = 3'd4;
    bus.dataAddr_i = 32'h0000_0140;
    bus.dataData_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.dataEn_i = 1'b0;
    check("abort_b0", bus.ramA_o, 32'h0000_0140);
    @(posedge clk); #1;
    check("abort_b1", bus.ramA_o, 32'h0000_0141);
    rst            = 1'b1;
    bus.dataEn_i   = 1'b1;
    bus.dataAddr_i = 32'h0000_0300;
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.dataEn_i = 1'b0;
    last_rd      = 32'd0;
    check("abort_wr", {31'd0, bus.ramWr_o}, 32'd0);
    check("abort_busy", {31'd0, bus.Busy_o}, 32'd0);
    check("abort_rdy", {31'd0, bus.Rdy_o}, 32'd0);
    check("abort_data", bus.dataData_o, 32'd0);
    do_req(1'b0, 3'd1, 32'h0000_0141, 32'd0, 1, -1, 0, 32'h0000_00BE);
    do_req(1'b0, 3'd2, 32'h0000_0142, 32'd0, 2, -1, 0, 32'h0000_1918);
    do_req(1'b0, 3'd1, 32'h0000_0300, 32'd0, 1, -1, 0, 32'h0000_005A);

`ifdef MEMCTRL_IO_STALL_EN
    // Byte store to the I/O window while the output buffer is full for 4 cycles
    bus.ioFull_i   = 1'b1;
    bus.dataEn_i   = 1'b1;
    bus.dataRw_i   = 1'b1;
    bus.dataWid_i  = 3'd1;
    bus.dataAddr_i = 32'h0003_0000;
    bus.dataData_i = 32'h0000_00A5;
    sb_q.push_back(last_rd);
    @(posedge clk); #1;
    bus.dataEn_i = 1'b0;
    check("io_busy", {31'd0, bus.Busy_o}, 32'd1);
    check("io_wr0", {31'd0, bus.ramWr_o}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("io_wait_wr", {31'd0, bus.ramWr_o}, 32'd0);
      check("io_wait_busy", {31'd0, bus.Busy_o}, 32'd1);
    end
    bus.ioFull_i = 1'b0;
    @(posedge clk); #1;
    check("io_wr", {31'd0, bus.ramWr_o}, 32'd1);
    check("io_a", bus.ramA_o, 32'h0003_0000);
    check("io_dout", {24'd0, bus.ramDout_o}, 32'h0000_00A5);
    check("io_rdy_low", {31'd0, bus.Rdy_o}, 32'd0);
    @(posedge clk); #1;
    check("io_rdy", {31'd0, bus.Rdy_o}, 32'd1);
    check("io_wr_end", {31'd0, bus.ramWr_o}, 32'd0);
`endif

    @(posedge clk); #1;
    check("rdy_one_cycle", {31'd0, bus.Rdy_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
